slt_serial_32bit: RTL and testbench
===================================

Name: slt_serial_32bit

Overview:
Multi-cycle, digit-serial set-less-than unit, the sequential counterpart to the combinational slt_32bit. It accepts two operands under a start/busy/done handshake and scans them MSB-first, DIGIT bits per cycle, stopping at the first differing digit. It returns the result in the same 32-bit SLT format, with bit 0 as the result and all other bits zero. It sits beside the ALU for the multi-cycle datapath variant, where comparison area is traded for latency.

Parameters:
WIDTH, 32, operand and result width.
DIGIT, 4, bits compared per cycle. Must divide WIDTH. NDIG = WIDTH/DIGIT (default 8).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
value1  in  WIDTH  operand A, sampled with start.
value2  in  WIDTH  operand B, sampled with start.
is_signed  in  1  1 = two's-complement compare; 0 = unsigned (SLTU). Sampled with start.
busy  out  1  high in COMPARE.
done  out  1  one-cycle pulse; result valid.
slt  out  WIDTH  {WIDTH-1 zeros, A<B}. Held until the next accepted start.
equal  out  1  A==B. Held like slt.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, slt=0, equal=0.
  - Operand registers and digit counter are cleared.
  - Reset asserted mid-compare aborts the compare with no done pulse.
- States:
  - IDLE: waits for start.
  - COMPARE: evaluates one digit per cycle.
  - DONE: lasts one cycle; done=1.
- IDLE with start=1 at edge E0:
  - Latch value1/value2 into shift registers.
  - If is_signed, invert the MSB of both latched operands. This offset-binary mapping makes the unsigned scan a correct signed compare.
  - cnt=NDIG-1. Go to COMPARE.
  - slt and equal keep their old values until the new decision.
- COMPARE, at each edge:
  - Compare the top DIGIT bits of A and B (unsigned).
  - If they differ: slt[0] <= (digitA < digitB), equal <= 0, go to DONE.
  - Else if cnt==0: slt <= 0, equal <= 1, go to DONE.
  - Else: shift both registers left by DIGIT, cnt <= cnt-1, stay in COMPARE.
- DONE: done=1 for exactly one cycle, then go to IDLE. A start in DONE is ignored; start is accepted only in IDLE.
- Latency: the first differing digit is k, with 1 = the MS digit. done is high in cycle k+1 after E0, where the cycle after E0 is cycle 1. Range: 2..NDIG+1 cycles. Back-to-back throughput is one operation per latency+1 cycles.
- start while busy or in DONE: ignored. Operands are not re-sampled and there is no error indication.
- Outputs are registered; no combinational path from inputs to outputs.
- slt[WIDTH-1:1] is always 0.

Decomposition:
- Shared package (alu_pkg), containing:
  - state encoding constants: ST_IDLE=2'd0, ST_COMPARE=2'd1, ST_DONE=2'd2;
  - SLT_TRUE and SLT_FALSE 32-bit result constants, shared with slt_32bit.
- One sub-module: slt_digit_cmp. A combinational DIGIT-bit unsigned compare with outputs lt and eq, instantiated once.
- Top level holds the FSM, shift registers and counter.

Test Plan:
1. Decision at the last digit: signed, A=000FFFF0, B=000FFFFF, start pulse → busy for 8 cycles; done in cycle 9; slt=00000001; equal=0.
2. Decision at the first digit: signed, A=40000000, B=3FFFFFFF → done in cycle 2; slt=00000000.
3. Sign handling: A=FFF00000, B=00000000:
   - with is_signed=1 → slt=00000001, done in cycle 2;
   - repeated with is_signed=0 → slt=00000000.
4. Equal operands: A=B=00000002 → slt=0, equal=1, done in cycle 9. Then A=1, B=2 → slt=1, done in cycle 9.
5. Handshake: start held high continuously with changing operands during a compare of 2 vs 1 → the first operands' result slt=0 is produced; the next operation begins only after returning to IDLE; exactly one done pulse per accepted start.
6. Reset mid-operation: rst_n=0 asynchronously during cycle 4 of a compare → busy, done and slt are 0 immediately; no done pulse; a new start after release returns correct results.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU compare constants and FSM state encoding
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [31:0] SLT_TRUE  = 32'h0000_0001;
  localparam logic [31:0] SLT_FALSE = 32'h0000_0000;

endpackage

// File: rtl/slt_serial_32bit_if.sv
// rtl/slt_serial_32bit_if.sv - start/busy/done operand and result bundle
interface slt_serial_32bit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] value1;
  logic [WIDTH-1:0] value2;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] slt;
  logic             equal;

  modport master (
    output start, value1, value2, is_signed,
    input  busy, done, slt, equal
  );

  modport slave (
    input  start, value1, value2, is_signed,
    output busy, done, slt, equal
  );

endinterface

// File: rtl/slt_serial_32bit_digit_cmp.sv
// rtl/slt_serial_32bit_digit_cmp.sv - combinational unsigned compare of one digit
module slt_digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/slt_serial_32bit.sv
// rtl/slt_serial_32bit.sv - digit-serial MSB-first set-less-than unit
module slt_serial_32bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  slt_serial_32bit_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] slt_q;
  logic             equal_q;
  logic             dig_lt, dig_eq;

  slt_digit_cmp #(.DIGIT(DIGIT)) u_cmp (
    .a  (a_sh[WIDTH-1 -: DIGIT]),
    .b  (b_sh[WIDTH-1 -: DIGIT]),
    .lt (dig_lt),
    .eq (dig_eq)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (bus.start) state_n = ST_COMPARE;
      ST_COMPARE: if (!dig_eq || cnt == '0) state_n = ST_DONE;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Flipping the sign bit maps two's complement onto offset binary, so the
  // unsigned digit scan orders signed operands correctly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      slt_q   <= '0;
      equal_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sh <= {bus.value1[WIDTH-1] ^ bus.is_signed, bus.value1[WIDTH-2:0]};
            b_sh <= {bus.value2[WIDTH-1] ^ bus.is_signed, bus.value2[WIDTH-2:0]};
            cnt  <= CW'(NDIG - 1);
          end
        end
        ST_COMPARE: begin
          if (!dig_eq) begin
            slt_q   <= dig_lt ? WIDTH'(SLT_TRUE) : WIDTH'(SLT_FALSE);
            equal_q <= 1'b0;
          end else if (cnt == '0) begin
            slt_q   <= WIDTH'(SLT_FALSE);
            equal_q <= 1'b1;
          end else begin
            a_sh <= a_sh << DIGIT;
            b_sh <= b_sh << DIGIT;
            cnt  <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state == ST_COMPARE);
  assign bus.done  = (state == ST_DONE);
  assign bus.slt   = slt_q;
  assign bus.equal = equal_q;

endmodule

// File: tb/tb_slt_serial_32bit.sv
// tb/tb_slt_serial_32bit.sv - randomized bench for slt_serial_32bit with reference model
module tb_slt_serial_32bit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] prev_slt;
  logic        prev_eq;

  slt_serial_32bit_if #(.WIDTH(32)) bus ();

  slt_serial_32bit #(.WIDTH(32), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_lt(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (s) return ($signed(a) < $signed(b));
    return (a < b);
  endfunction

  // Cycles from the accepting edge to the done cycle: position of the first
  // differing 4-bit digit from the top, plus one.
  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    x = a ^ b;
    if (x == 0) return 9;
    for (int p = 31; p >= 0; p--)
      if (x[p]) return (31 - p) / 4 + 2;
    return 9;
  endfunction

  // Entered at the falling edge of cycle 1 after the accepting edge; returns at
  // the falling edge of the done cycle (scramble=1) or one cycle later.
  task automatic finish_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input bit scramble);
    int          done_cyc;
    int          busy_n;
    int          lat;
    logic [31:0] exp_slt;
    done_cyc = 0;
    busy_n   = 0;
    lat      = model_lat(a, b);
    exp_slt  = {31'b0, model_lt(a, b, s)};
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      if (c == 1) begin
        check("slt_held", bus.slt, prev_slt);
        check("eq_held", {31'b0, bus.equal}, {31'b0, prev_eq});
      end
      if (scramble) begin
        bus.value1    = $urandom;
        bus.value2    = $urandom;
        bus.is_signed = 1'($urandom_range(0, 1));
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("latency", done_cyc, lat);
    check("busy_cycles", busy_n, lat - 1);
    check("slt", bus.slt, exp_slt);
    check("equal", {31'b0, bus.equal}, {31'b0, a == b});
    prev_slt = exp_slt;
    prev_eq  = (a == b);
    if (!scramble) begin
      @(negedge clk);
      check("done_pulse", {31'b0, bus.done}, 32'd0);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.value1    = a;
    bus.value2    = b;
    bus.is_signed = s;
    @(negedge clk);
    finish_op(a, b, s, 1'b0);
  endtask

  initial begin
    int          pulses;
    logic [31:0] ra, rb;
    logic        rs;
    total         = 0;
    bad           = 0;
    prev_slt      = 32'd0;
    prev_eq       = 1'b0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.value1    = '0;
    bus.value2    = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_slt", bus.slt, 32'd0);
    check("rst_equal", {31'b0, bus.equal}, 32'd0);
    rst_n = 1'b1;

    run_op(32'h000F_FFF0, 32'h000F_FFFF, 1'b1);
    run_op(32'h4000_0000, 32'h3FFF_FFFF, 1'b1);
    run_op(32'hFFF0_0000, 32'h0000_0000, 1'b1);
    run_op(32'hFFF0_0000, 32'h0000_0000, 1'b0);
    run_op(32'h0000_0002, 32'h0000_0002, 1'b1);
    run_op(32'h0000_0001, 32'h0000_0002, 1'b1);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);

    // start held high across a compare while operands keep changing
    @(negedge clk);
    bus.start     = 1'b1;
    bus.value1    = 32'd2;
    bus.value2    = 32'd1;
    bus.is_signed = 1'b0;
    @(negedge clk);
    finish_op(32'd2, 32'd1, 1'b0, 1'b1);
    bus.value1    = 32'hFFFF_FFF5;
    bus.value2    = 32'h0000_0009;
    bus.is_signed = 1'b1;
    @(negedge clk);
    check("hs_idle_busy", {31'b0, bus.busy}, 32'd0);
    check("hs_idle_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    finish_op(32'hFFFF_FFF5, 32'h0000_0009, 1'b1, 1'b0);

    // asynchronous reset in cycle 4 of a full-length compare
    @(negedge clk);
    bus.start     = 1'b1;
    bus.value1    = 32'd1;
    bus.value2    = 32'd2;
    bus.is_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'b0, bus.done}, 32'd0);
    check("mid_rst_slt", bus.slt, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    check("mid_rst_quiet", pulses, 0);
    prev_slt = 32'd0;
    prev_eq  = 1'b0;
    run_op(32'h0000_0003, 32'h0000_0007, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (32'($urandom_range(1, 15)) << (4 * $urandom_range(0, 7)));
        2: rb = ra ^ 32'h8000_0000;
        default: rb = $urandom;
      endcase
      run_op(ra, rb, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
